// File: rtl/pwm_ctrl_pkg.sv
// Shared types and step arithmetic for the PWM ramp sequencer.
// next_threshold works on a wide unsigned range so steps saturate at the target.
package pwm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WRAP,
        LOAD,
        HOLD,
        DONE
    } ramp_state_t;

    localparam int unsigned TH_W = 16;
    localparam int unsigned XW   = TH_W + 1;

    function automatic logic [XW-1:0] next_threshold(
        input logic [XW-1:0] current,
        input logic [XW-1:0] target,
        input logic [XW-1:0] step
    );
        logic [XW-1:0] diff;
        if (target >= current)
            diff = target - current;
        else
            diff = current - target;
        if (step == '0 || diff <= step)
            return target;
        else if (target > current)
            return current + step;
        else
            return current - step;
    endfunction

endpackage

// File: rtl/pwm_ramp_controller.sv
// Ramps a pwm_generator threshold toward a target, one step per
// period boundary, with an optional dwell of extra periods per step.
module pwm_ramp_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int n_bit      = 8,
    parameter int dwell_bits = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  abort,
    input  logic [n_bit-1:0]      target,
    input  logic [n_bit-1:0]      step,
    input  logic [dwell_bits-1:0] dwell,
    input  logic [n_bit-1:0]      count_in,
    output logic                  pwm_enable,
    output logic                  pwm_load,
    output logic [n_bit-1:0]      pwm_threshold,
    output logic                  busy,
    output logic                  done
);

    ramp_state_t state, state_nxt;

    logic [n_bit-1:0]      tgt_q;
    logic [n_bit-1:0]      step_q;
    logic [n_bit-1:0]      thr_q;
    logic [n_bit-1:0]      next_thr;
    logic [dwell_bits-1:0] dwell_q;
    logic [dwell_bits-1:0] dwell_cnt;
    logic                  wrap;
    logic                  accept;

    assign wrap   = enable && (count_in == '1);
    assign accept = start && !abort;

    assign next_thr = n_bit'(next_threshold(
        XW'(thr_q), XW'(tgt_q), XW'(step_q)));

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Threshold only changes on an un-aborted wrap, so it is glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            tgt_q     <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            thr_q     <= '0;
            dwell_cnt <= '0;
        end else begin
            if (state == IDLE && accept) begin
                tgt_q   <= target;
                step_q  <= step;
                dwell_q <= dwell;
            end
            if (state == WAIT_WRAP && wrap && !abort)
                thr_q <= next_thr;
            if (state == LOAD && state_nxt == HOLD)
                dwell_cnt <= dwell_q;
            else if (state == HOLD && wrap && !abort)
                dwell_cnt <= dwell_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (target == thr_q) ? DONE : WAIT_WRAP;
            end
            WAIT_WRAP: begin
                if (abort)
                    state_nxt = IDLE;
                else if (wrap)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (abort)
                    state_nxt = IDLE;
                else if (thr_q == tgt_q)
                    state_nxt = DONE;
                else if (dwell_q == '0)
                    state_nxt = WAIT_WRAP;
                else
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (abort)
                    state_nxt = IDLE;
                else if (wrap && dwell_cnt <= dwell_bits'(1))
                    state_nxt = WAIT_WRAP;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pwm_load = 1'b0;
        done     = 1'b0;
        busy     = 1'b0;
        unique case (state)
            WAIT_WRAP: busy = 1'b1;
            HOLD:      busy = 1'b1;
            LOAD: begin
                busy     = 1'b1;
                pwm_load = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign pwm_enable    = enable;
    assign pwm_threshold = thr_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller driving a behavioural 4-bit generator.
// Stimulus queues expected load/done events; a negedge monitor checks them.
module tb_pwm_ramp_controller;

    localparam int NB = 4;
    localparam int DB = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          start;
    logic          abort;
    logic [NB-1:0] target;
    logic [NB-1:0] step;
    logic [DB-1:0] dwell;
    logic [NB-1:0] count_in;
    logic          pwm_enable;
    logic          pwm_load;
    logic [NB-1:0] pwm_threshold;
    logic          busy;
    logic          done;

    pwm_ramp_controller #(.n_bit(NB), .dwell_bits(DB)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .start         (start),
        .abort         (abort),
        .target        (target),
        .step          (step),
        .dwell         (dwell),
        .count_in      (count_in),
        .pwm_enable    (pwm_enable),
        .pwm_load      (pwm_load),
        .pwm_threshold (pwm_threshold),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    // Generator: load has priority and clears the count.
    always_ff @(posedge clock) begin
        if (reset)
            count_in <= '0;
        else if (pwm_load)
            count_in <= '0;
        else if (pwm_enable)
            count_in <= count_in + 1'b1;
    end

    int cyc = 0;
    always_ff @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int val;
        int ref_kind;
        int gap;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int passed = 0;
    int start_cyc = 0;
    int last_ev = 0;
    int ev_seen = 0;
    int loads_seen = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic void push(bit d, int v, int rk, int g);
        exp_t e;
        e.is_done  = d;
        e.val      = v;
        e.ref_kind = rk;
        e.gap      = g;
        q.push_back(e);
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset && (pwm_load || done)) begin
            ev_seen++;
            if (pwm_load) loads_seen++;
            chk("event_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("event_kind", int'(done), int'(e.is_done));
                chk("load_done_excl", int'(pwm_load && done), 0);
                chk("threshold", int'(pwm_threshold), e.val);
                if (pwm_load) chk("load_at_count0", int'(count_in), 0);
                if (done) chk("busy_low_at_done", int'(busy), 0);
                if (e.ref_kind == 1)
                    chk("gap_prev", cyc - last_ev, e.gap);
                else if (e.ref_kind == 2)
                    chk("gap_start", cyc - start_cyc, e.gap);
            end
            last_ev = cyc;
        end
    end

    task automatic do_reset(logic en);
        @(posedge clock); #1;
        reset = 1'b1; enable = en; start = 1'b0; abort = 1'b0;
        target = '0; step = '0; dwell = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start(int t, int s, int d, logic ab, int exp_busy);
        @(posedge clock); #1;
        target = NB'(t); step = NB'(s); dwell = DB'(d);
        start = 1'b1; abort = ab;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        start_cyc = cyc - 1;
        @(negedge clock);
        chk("busy_after_start", int'(busy), exp_busy);
    endtask

    task automatic wait_load(int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!pwm_load && n < budget);
        chk("saw_load", int'(pwm_load), 1);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int e0;
        reset = 1'b1; enable = 1'b0; start = 1'b0; abort = 1'b0;
        target = '0; step = '0; dwell = '0;

        // Reset values, then idle with enable high: no loads.
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_threshold", int'(pwm_threshold), 0);
        chk("rst_load", int'(pwm_load), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        do_reset(1'b1);
        e0 = loads_seen;
        repeat (40) @(negedge clock);
        chk("idle_no_load", loads_seen - e0, 0);
        chk("pwm_enable_hi", int'(pwm_enable), 1);

        // Upward ramp 0 -> 12 by 4.
        push(0, 4, 0, 0); push(0, 8, 1, 17); push(0, 12, 1, 17);
        push(1, 12, 1, 1);
        pulse_start(12, 4, 0, 1'b0, 1);
        wait_drain(200);

        // Downward saturating ramp 12 -> 1 by 5.
        push(0, 7, 0, 0); push(0, 2, 1, 17); push(0, 1, 1, 17);
        push(1, 1, 1, 1);
        pulse_start(1, 5, 0, 1'b0, 1);
        wait_drain(200);

        // Step 0 jumps straight to target.
        push(0, 9, 0, 0); push(1, 9, 1, 1);
        pulse_start(9, 0, 0, 1'b0, 1);
        wait_drain(100);

        // Target equals current: done at t+1, no load, never busy.
        e0 = loads_seen;
        push(1, 9, 2, 1);
        pulse_start(9, 3, 0, 1'b0, 0);
        wait_drain(20);
        chk("same_no_load", loads_seen - e0, 0);

        // Dwell of 2 periods per step.
        do_reset(1'b1);
        push(0, 4, 0, 0); push(0, 8, 1, 49); push(1, 8, 1, 1);
        pulse_start(8, 4, 2, 1'b0, 1);
        wait_drain(300);

        // Enable dropped 40 cycles mid-HOLD stretches the gap by 40.
        do_reset(1'b1);
        push(0, 4, 0, 0); push(0, 8, 1, 89); push(1, 8, 1, 1);
        pulse_start(8, 4, 2, 1'b0, 1);
        wait_load(100);
        repeat (10) @(posedge clock);
        #1 enable = 1'b0;
        @(negedge clock);
        chk("pwm_enable_lo", int'(pwm_enable), 0);
        repeat (40) @(posedge clock);
        #1 enable = 1'b1;
        wait_drain(300);

        // Abort during HOLD keeps threshold, no done.
        do_reset(1'b1);
        push(0, 4, 0, 0);
        pulse_start(8, 4, 2, 1'b0, 1);
        wait_load(100);
        repeat (5) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_threshold", int'(pwm_threshold), 4);
        e0 = ev_seen;
        repeat (120) @(negedge clock);
        chk("abort_quiet", ev_seen - e0, 0);
        chk("abort_drain", q.size(), 0);

        // Start and abort together in IDLE: abort wins.
        e0 = ev_seen;
        pulse_start(9, 2, 0, 1'b1, 0);
        repeat (40) @(negedge clock);
        chk("start_abort_quiet", ev_seen - e0, 0);
        chk("start_abort_thr", int'(pwm_threshold), 4);

        // Start while busy is ignored.
        do_reset(1'b1);
        push(0, 4, 0, 0); push(0, 8, 1, 17); push(0, 12, 1, 17);
        push(1, 12, 1, 1);
        pulse_start(12, 4, 0, 1'b0, 1);
        wait_load(100);
        repeat (3) @(posedge clock);
        pulse_start(2, 1, 5, 1'b0, 1);
        wait_drain(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
